// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map, bit positions,
// frame length and sequencer state encoding.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam int STAT_OVR    = 4;
  localparam int STAT_FULL   = 3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Start bit, 8 data bits, stop bit.
  localparam int FRAME_LEN = 10;
  localparam int PULSE_W   = 4;

  localparam logic [15:0] DIV_RST_DEFAULT = 16'd868;
  localparam logic [15:0] DIV_MIN         = 16'd2;

  typedef enum logic {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } seq_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO; a push into a full FIFO is accepted only when a pop happens
// in the same cycle, otherwise the byte is discarded.
module uart_rx_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; count/pointers define which entries are valid,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchroniser, bit-sample sequencer/divider, register
// block and receive FIFO. Optional interrupt enabled by macro UART_RX_CTRL_IRQ_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] DIV_RST = DIV_RST_DEFAULT,
  parameter int          FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx_line,
  output logic        bclk,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  output logic        irq
);

  logic rx_s1, rx_s2, rx_d;
  logic line_fall;

  seq_state_t         state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [PULSE_W-1:0] pulses, pulses_nxt;
  logic [15:0]        div_eff;

  logic        en;
  logic        irq_en;
  logic [15:0] div_reg;
  logic        ovr;
  logic        rdy_d;
  logic [31:0] read_word;

  logic             wr_ctrl, wr_div, wr_status;
  logic             push_req, pop_req, drop;
  logic [7:0]       fifo_dout;
  logic [FIFO_AW:0] count;
  logic             full, empty;
  logic             unused_bits;

  assign unused_bits = ^wdata[31:16];

  // Idle line is high; starting the synchroniser at 1 avoids a false start after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign line_fall = rx_d && !rx_s2;
  assign div_eff   = clamp_div(div_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= HUNT;
      cnt    <= '0;
      pulses <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pulses <= pulses_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pulses_nxt = pulses;
    bclk       = 1'b0;
    case (state)
      HUNT: begin
        if (en && line_fall) begin
          state_nxt  = FRAME;
          cnt_nxt    = div_eff >> 1;
          pulses_nxt = '0;
        end
      end
      FRAME: begin
        if (cnt == '0) begin
          bclk       = 1'b1;
          cnt_nxt    = div_eff - 16'd1;
          pulses_nxt = pulses + PULSE_W'(1);
          if (pulses == PULSE_W'(FRAME_LEN - 1)) state_nxt = HUNT;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (!en) begin
      state_nxt = HUNT;
      bclk      = 1'b0;
    end
  end

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_div    = we && (addr == ADDR_DIV);
  assign wr_status = we && (addr == ADDR_STATUS);
  assign push_req  = rx_rdy && !rdy_d;
  assign pop_req   = re && (addr == ADDR_DATA) && !empty;
  assign drop      = push_req && full && !pop_req;

  uart_rx_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_DATA:   if (!empty) read_word[7:0] = fifo_dout;
      ADDR_STATUS: begin
        read_word[STAT_OVR]  = ovr;
        read_word[STAT_FULL] = full;
        read_word[2:0]       = 3'(count);
      end
      ADDR_CTRL: begin
        read_word[CTRL_EN]     = en;
        read_word[CTRL_IRQ_EN] = irq_en;
      end
      default:     read_word[15:0] = div_reg;
    endcase
  end

  // rdy_d resets high so a ready flag still asserted at reset release is not taken
  // as a fresh byte from an aborted frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      div_reg <= DIV_RST;
      ovr     <= 1'b0;
      rdata   <= '0;
      rdy_d   <= 1'b1;
    end else begin
      rdy_d <= rx_rdy;
      if (wr_ctrl) en <= wdata[CTRL_EN];
      if (wr_div)  div_reg <= wdata[15:0];
      if (drop)                               ovr <= 1'b1;
      else if (wr_status && wdata[STAT_OVR])  ovr <= 1'b0;
      if (re) rdata <= read_word;
    end
  end

`ifdef UART_RX_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         irq_en <= 1'b0;
    else if (wr_ctrl) irq_en <= wdata[CTRL_IRQ_EN];
  end

  assign irq = irq_en && (!empty || ovr);
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule
